// File: rtl/uart_reg_bridge.sv
// Command-frame parser between the UART byte stream and a register file.
// 'W' addr data -> write + 'K'; 'R' addr -> read + data bytes; anything else -> '?'.
module uart_reg_bridge #(
    parameter int ADDR_BYTES = 1,
    parameter int DATA_BYTES = 4,
    parameter int TIMEOUT    = 1000000
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [7:0]              rx_data_i,
    input  logic                    rx_valid_i,
    output logic [7:0]              tx_data_o,
    output logic                    tx_valid_o,
    output logic [8*ADDR_BYTES-1:0] reg_addr_o,
    output logic [8*DATA_BYTES-1:0] reg_wdata_o,
    output logic                    reg_we_o,
    output logic                    reg_re_o,
    input  logic [8*DATA_BYTES-1:0] reg_rdata_i,
    output logic                    timeout_o,
    output logic                    overrun_o
);
    localparam int AW   = 8 * ADDR_BYTES;
    localparam int DW   = 8 * DATA_BYTES;
    localparam int MAXB = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
    localparam int CW   = $clog2(MAXB + 1);
    localparam int TW   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_EXEC, S_WAIT_RD, S_RESP
    } state_t;

    state_t          state_reg, state_next;
    logic            op_wr_reg, op_wr_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [TW-1:0]   tmo_reg, tmo_next;
    logic [AW-1:0]   addr_reg, addr_next;
    logic [DW-1:0]   wdata_reg, wdata_next;
    logic [DW-1:0]   shift_reg, shift_next;
    logic            timeout_reg, timeout_next;
    logic            overrun_reg, overrun_next;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg   <= S_IDLE;
            op_wr_reg   <= 1'b0;
            cnt_reg     <= '0;
            tmo_reg     <= '0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            shift_reg   <= '0;
            timeout_reg <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            op_wr_reg   <= op_wr_next;
            cnt_reg     <= cnt_next;
            tmo_reg     <= tmo_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            shift_reg   <= shift_next;
            timeout_reg <= timeout_next;
            overrun_reg <= overrun_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        op_wr_next   = op_wr_reg;
        cnt_next     = cnt_reg;
        tmo_next     = tmo_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        shift_next   = shift_reg;
        timeout_next = 1'b0;
        overrun_next = overrun_reg;

        case (state_reg)
            S_IDLE: begin
                tmo_next = '0;
                if (rx_valid_i) begin
                    cnt_next = '0;
                    if (rx_data_i == 8'h57 || rx_data_i == 8'h52) begin
                        op_wr_next = (rx_data_i == 8'h57);
                        state_next = S_ADDR;
                    end else begin
                        shift_next = DW'(8'h3F) << (DW - 8);
                        state_next = S_RESP;
                    end
                end
            end
            S_ADDR: begin
                if (rx_valid_i) begin
                    tmo_next  = '0;
                    addr_next = (addr_reg << 8) | AW'(rx_data_i);
                    if (cnt_reg == CW'(ADDR_BYTES - 1)) begin
                        cnt_next   = '0;
                        state_next = op_wr_reg ? S_DATA : S_EXEC;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end else if (tmo_reg == TW'(TIMEOUT - 1)) begin
                    // Silence for TIMEOUT cycles: drop the partial frame quietly.
                    tmo_next     = '0;
                    cnt_next     = '0;
                    timeout_next = 1'b1;
                    state_next   = S_IDLE;
                end else begin
                    tmo_next = tmo_reg + TW'(1);
                end
            end
            S_DATA: begin
                if (rx_valid_i) begin
                    tmo_next   = '0;
                    wdata_next = (wdata_reg << 8) | DW'(rx_data_i);
                    if (cnt_reg == CW'(DATA_BYTES - 1)) begin
                        cnt_next   = '0;
                        state_next = S_EXEC;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end else if (tmo_reg == TW'(TIMEOUT - 1)) begin
                    tmo_next     = '0;
                    cnt_next     = '0;
                    timeout_next = 1'b1;
                    state_next   = S_IDLE;
                end else begin
                    tmo_next = tmo_reg + TW'(1);
                end
            end
            S_EXEC: begin
                if (op_wr_reg) begin
                    shift_next = DW'(8'h4B) << (DW - 8);
                    cnt_next   = '0;
                    state_next = S_RESP;
                end else begin
                    state_next = S_WAIT_RD;
                end
            end
            S_WAIT_RD: begin
                shift_next = reg_rdata_i;
                cnt_next   = CW'(DATA_BYTES - 1);
                state_next = S_RESP;
            end
            S_RESP: begin
                // cnt_reg holds the number of bytes still to follow this one.
                shift_next = shift_reg << 8;
                if (cnt_reg == '0) begin
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (rx_valid_i && (state_reg == S_EXEC || state_reg == S_WAIT_RD || state_reg == S_RESP)) begin
            overrun_next = 1'b1;
        end
    end

    assign tx_valid_o  = (state_reg == S_RESP);
    assign tx_data_o   = shift_reg[DW-1 -: 8];
    assign reg_addr_o  = addr_reg;
    assign reg_wdata_o = wdata_reg;
    assign reg_we_o    = (state_reg == S_EXEC) && op_wr_reg;
    assign reg_re_o    = (state_reg == S_EXEC) && !op_wr_reg;
    assign timeout_o   = timeout_reg;
    assign overrun_o   = overrun_reg;
endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed bench for uart_reg_bridge: write, read, unknown byte, timeout, overrun, reset mid-response.
module tb_uart_reg_bridge;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [7:0]  rx_data_i = 8'h00;
    logic        rx_valid_i = 1'b0;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic [7:0]  reg_addr_o;
    logic [31:0] reg_wdata_o;
    logic        reg_we_o;
    logic        reg_re_o;
    logic [31:0] reg_rdata_i = 32'h0;
    logic        timeout_o;
    logic        overrun_o;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    uart_reg_bridge #(.ADDR_BYTES(1), .DATA_BYTES(4), .TIMEOUT(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o),
        .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o),
        .reg_we_o(reg_we_o), .reg_re_o(reg_re_o), .reg_rdata_i(reg_rdata_i),
        .timeout_o(timeout_o), .overrun_o(overrun_o)
    );

    // Drive one byte for one cycle; returns #1 into the following cycle.
    task automatic send_byte(input logic [7:0] b);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        @(posedge clk_i); #1;
        rx_valid_i = 1'b0;
    endtask

    task automatic step();
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({tx_valid_o, tx_data_o, reg_we_o, reg_re_o, reg_addr_o, reg_wdata_o, timeout_o, overrun_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got tx_v=%b tx=%h we=%b re=%b addr=%h wdata=%h to=%b ov=%b required all 0",
                     tx_valid_o, tx_data_o, reg_we_o, reg_re_o, reg_addr_o, reg_wdata_o, timeout_o, overrun_o);
        end
        step(); step();
        rst_i = 1'b0;
        step();
        $display("reset: released");
    endtask

    task automatic test_write();
        send_byte(8'h57); send_byte(8'h10); send_byte(8'hDE);
        send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        // T+1
        checks++;
        if (reg_we_o !== 1'b1 || reg_re_o !== 1'b0 || tx_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL write_strobe: got we=%b re=%b tx_v=%b required we=1 re=0 tx_v=0", reg_we_o, reg_re_o, tx_valid_o);
        end
        checks++;
        if (reg_addr_o !== 8'h10 || reg_wdata_o !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL write_bus: got addr=%h wdata=%h required 10 deadbeef", reg_addr_o, reg_wdata_o);
        end
        step(); // T+2
        checks++;
        if (reg_we_o !== 1'b0 || tx_valid_o !== 1'b1 || tx_data_o !== 8'h4B) begin
            failures++;
            $display("FAIL write_ack: got we=%b tx_v=%b tx=%h required we=0 tx_v=1 tx=4b", reg_we_o, tx_valid_o, tx_data_o);
        end
        step(); // T+3
        checks++;
        if (tx_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL write_ack_len: got tx_v=%b required 0", tx_valid_o);
        end
        $display("write: addr=10 data=deadbeef");
    endtask

    task automatic test_read(input logic [7:0] addr, input logic [31:0] rdata);
        logic [31:0] exp_word;
        exp_word = rdata;
        send_byte(8'h52); send_byte(addr);
        // T+1
        checks++;
        if (reg_re_o !== 1'b1 || reg_we_o !== 1'b0 || reg_addr_o !== addr) begin
            failures++;
            $display("FAIL read_strobe: got re=%b we=%b addr=%h required re=1 we=0 addr=%h", reg_re_o, reg_we_o, reg_addr_o, addr);
        end
        step(); // T+2: rdata presented now, captured at end of this cycle
        reg_rdata_i = rdata;
        checks++;
        if (reg_re_o !== 1'b0 || tx_valid_o !== 1'b0 || reg_addr_o !== addr) begin
            failures++;
            $display("FAIL read_wait: got re=%b tx_v=%b addr=%h required re=0 tx_v=0 addr=%h", reg_re_o, tx_valid_o, reg_addr_o, addr);
        end
        step(); // T+3
        reg_rdata_i = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tx_valid_o !== 1'b1 || tx_data_o !== exp_word[31:24]) begin
                failures++;
                $display("FAIL read_byte%0d: got tx_v=%b tx=%h required tx_v=1 tx=%h", i, tx_valid_o, tx_data_o, exp_word[31:24]);
            end
            exp_word = exp_word << 8;
            step();
        end
        checks++;
        if (tx_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL read_end: got tx_v=%b required 0", tx_valid_o);
        end
        $display("read: addr=%h data=%h", addr, rdata);
    endtask

    task automatic test_unknown();
        send_byte(8'h41);
        checks++;
        if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h3F) begin
            failures++;
            $display("FAIL unknown_resp: got tx_v=%b tx=%h required tx_v=1 tx=3f", tx_valid_o, tx_data_o);
        end
        step();
        checks++;
        if (tx_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL unknown_len: got tx_v=%b required 0", tx_valid_o);
        end
        $display("unknown: 41 -> 3f");
        test_read(8'h20, 32'hCAFEF00D);
    endtask

    task automatic test_timeout();
        int seen_at = 0;
        int pulses = 0;
        int bus_or_tx = 0;
        send_byte(8'h57); send_byte(8'h10);
        for (int n = 1; n <= 30; n++) begin
            if (timeout_o === 1'b1) begin
                pulses++;
                if (seen_at == 0) seen_at = n;
            end
            if (reg_we_o !== 1'b0 || reg_re_o !== 1'b0 || tx_valid_o !== 1'b0) bus_or_tx++;
            step();
        end
        checks++;
        if (seen_at < 16 || seen_at > 17) begin
            failures++;
            $display("FAIL timeout_time: got pulse at idle cycle %0d required 16..17", seen_at);
        end
        checks++;
        if (pulses !== 1) begin
            failures++;
            $display("FAIL timeout_width: got %0d pulse cycles required 1", pulses);
        end
        checks++;
        if (bus_or_tx !== 0) begin
            failures++;
            $display("FAIL timeout_quiet: got %0d cycles with bus/tx activity required 0", bus_or_tx);
        end
        $display("timeout: pulse at idle cycle %0d", seen_at);
        test_read(8'h05, 32'h7654_3210);
    endtask

    task automatic test_overrun();
        send_byte(8'h52); send_byte(8'h20); // T+1
        step();                              // T+2
        reg_rdata_i = 32'h0123_4567;
        step();                              // T+3
        reg_rdata_i = 32'h0;
        checks++;
        if (overrun_o !== 1'b0 || tx_data_o !== 8'h01 || tx_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL overrun_pre: got ov=%b tx_v=%b tx=%h required ov=0 tx_v=1 tx=01", overrun_o, tx_valid_o, tx_data_o);
        end
        step();                              // T+4: byte strobed during RESP
        send_byte(8'h57);                    // T+5
        checks++;
        if (overrun_o !== 1'b1 || tx_valid_o !== 1'b1 || tx_data_o !== 8'h45) begin
            failures++;
            $display("FAIL overrun_set: got ov=%b tx_v=%b tx=%h required ov=1 tx_v=1 tx=45", overrun_o, tx_valid_o, tx_data_o);
        end
        step(); step();                      // T+7
        checks++;
        if (tx_valid_o !== 1'b0 || overrun_o !== 1'b1) begin
            failures++;
            $display("FAIL overrun_end: got tx_v=%b ov=%b required tx_v=0 ov=1", tx_valid_o, overrun_o);
        end
        step(); step();
        // A fresh unknown byte answered with '?' proves the FSM is back in IDLE.
        send_byte(8'h41);
        checks++;
        if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h3F || overrun_o !== 1'b1 || reg_we_o !== 1'b0) begin
            failures++;
            $display("FAIL overrun_idle: got tx_v=%b tx=%h ov=%b we=%b required 1 3f 1 0", tx_valid_o, tx_data_o, overrun_o, reg_we_o);
        end
        step();
        $display("overrun: sticky=%b", overrun_o);
    endtask

    task automatic test_reset_mid_resp();
        int stray = 0;
        send_byte(8'h52); send_byte(8'h30);
        step();
        reg_rdata_i = 32'h89AB_CDEF;
        step();                              // T+3: byte 89
        reg_rdata_i = 32'h0;
        step();                              // T+4: byte AB
        checks++;
        if (tx_valid_o !== 1'b1 || tx_data_o !== 8'hAB) begin
            failures++;
            $display("FAIL rst_pre: got tx_v=%b tx=%h required tx_v=1 tx=ab", tx_valid_o, tx_data_o);
        end
        step();                              // T+5
        rst_i = 1'b1;
        #1;
        checks++;
        if ({tx_valid_o, tx_data_o, reg_we_o, reg_re_o, reg_addr_o, reg_wdata_o, timeout_o, overrun_o} !== '0) begin
            failures++;
            $display("FAIL rst_async: got tx_v=%b tx=%h we=%b re=%b addr=%h wdata=%h to=%b ov=%b required all 0",
                     tx_valid_o, tx_data_o, reg_we_o, reg_re_o, reg_addr_o, reg_wdata_o, timeout_o, overrun_o);
        end
        step();
        rst_i = 1'b0;
        for (int n = 0; n < 6; n++) begin
            if (tx_valid_o !== 1'b0) stray++;
            step();
        end
        checks++;
        if (stray !== 0) begin
            failures++;
            $display("FAIL rst_no_tx: got %0d tx strobes after reset required 0", stray);
        end
        $display("reset: mid-response abandoned");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read(8'h20, 32'h0123_4567);
        test_unknown();
        test_timeout();
        test_overrun();
        test_reset_mid_resp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
